// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control unit: state sequencer, ALU decode, NZCV register, condition gating.
// Latency FETCH-to-FETCH: DP 4, LDR 5, STR 4, B 3, undefined 2; no backpressure (free-running).
module multicycle_controller (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Instr,
   input  logic [3:0]  ALUFlags,
   output logic        PCWrite,
   output logic        AdrSrc,
   output logic        MemW,
   output logic        IRWrite,
   output logic [1:0]  ResultSrc,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ALUControl,
   output logic [1:0]  ImmSrc,
   output logic [1:0]  RegSrc,
   output logic        RegW,
   output logic [3:0]  Flags,
   output logic [3:0]  State
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXECR  = 4'd6,
      S_EXECI  = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9
   } state_t;

   state_t     state_q, state_d, cur_state;
   logic [3:0] flags_q, flags_d;

   logic [1:0] op;
   logic       imm_bit, s_bit, u_bit;
   logic [3:0] cmd, rd, cond;
   logic       unused_instr_bits;

   assign op      = Instr[27:26];
   assign imm_bit = Instr[25];
   assign cmd     = Instr[24:21];
   assign u_bit   = Instr[23];
   assign s_bit   = Instr[20];
   assign rd      = Instr[15:12];
   assign cond    = Instr[31:28];
   assign unused_instr_bits = ^{Instr[19:16], Instr[11:0]};

   assign ImmSrc = op;
   assign RegSrc = {op == 2'b01, op == 2'b10};
   assign Flags  = flags_q;
   assign State  = state_q;

   logic n_f, z_f, c_f, v_f, cond_ex;
   assign {n_f, z_f, c_f, v_f} = flags_q;

   always_comb begin
      cond_ex = 1'b0;
      case (cond)
         4'h0: cond_ex = z_f;
         4'h1: cond_ex = ~z_f;
         4'h2: cond_ex = c_f;
         4'h3: cond_ex = ~c_f;
         4'h4: cond_ex = n_f;
         4'h5: cond_ex = ~n_f;
         4'h6: cond_ex = v_f;
         4'h7: cond_ex = ~v_f;
         4'h8: cond_ex = c_f & ~z_f;
         4'h9: cond_ex = ~c_f | z_f;
         4'hA: cond_ex = (n_f == v_f);
         4'hB: cond_ex = (n_f != v_f);
         4'hC: cond_ex = ~z_f & (n_f == v_f);
         4'hD: cond_ex = z_f | (n_f != v_f);
         4'hE: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end

   // Compare-type ops only make sense with S set; otherwise treat as a no-op.
   logic [1:0] dec_alu_ctl, dec_flag_w;
   logic       dec_no_write;

   always_comb begin
      dec_alu_ctl  = 2'b00;
      dec_flag_w   = 2'b00;
      dec_no_write = 1'b1;
      case (cmd)
         4'b0100: begin dec_alu_ctl = 2'b00; dec_flag_w = s_bit ? 2'b11 : 2'b00; dec_no_write = 1'b0; end
         4'b0010: begin dec_alu_ctl = 2'b01; dec_flag_w = s_bit ? 2'b11 : 2'b00; dec_no_write = 1'b0; end
         4'b0000: begin dec_alu_ctl = 2'b10; dec_flag_w = s_bit ? 2'b10 : 2'b00; dec_no_write = 1'b0; end
         4'b1100: begin dec_alu_ctl = 2'b11; dec_flag_w = s_bit ? 2'b10 : 2'b00; dec_no_write = 1'b0; end
         4'b1010: if (s_bit) begin dec_alu_ctl = 2'b01; dec_flag_w = 2'b11; end
         4'b1011: if (s_bit) begin dec_alu_ctl = 2'b00; dec_flag_w = 2'b11; end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         flags_q <= 4'b0000;
      end else begin
         state_q <= state_d;
         flags_q <= flags_d;
      end
   end

   always_comb begin
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemW       = 1'b0;
      IRWrite    = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ALUControl = 2'b00;
      RegW       = 1'b0;
      state_d    = S_FETCH;
      flags_d    = flags_q;
      // While reset is high the datapath sees a quiet FETCH so nothing partial commits.
      cur_state  = reset ? S_FETCH : state_q;

      case (cur_state)
         S_FETCH: begin
            IRWrite   = 1'b1;
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            PCWrite   = 1'b1;
            state_d   = S_DECODE;
         end
         S_DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            case (op)
               2'b01:   state_d = S_MEMADR;
               2'b00:   state_d = imm_bit ? S_EXECI : S_EXECR;
               2'b10:   state_d = S_BRANCH;
               default: state_d = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            ALUSrcB    = 2'b01;
            ALUControl = u_bit ? 2'b00 : 2'b01;
            state_d    = s_bit ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            AdrSrc  = 1'b1;
            state_d = S_MEMWB;
         end
         S_MEMWB: begin
            ResultSrc = 2'b01;
            RegW      = cond_ex;
            PCWrite   = cond_ex & (rd == 4'hF);
         end
         S_MEMWR: begin
            AdrSrc = 1'b1;
            MemW   = cond_ex;
         end
         S_EXECR, S_EXECI: begin
            ALUSrcB    = (cur_state == S_EXECI) ? 2'b01 : 2'b00;
            ALUControl = dec_alu_ctl;
            state_d    = S_ALUWB;
            if (cond_ex) begin
               if (dec_flag_w[1]) flags_d[3:2] = ALUFlags[3:2];
               if (dec_flag_w[0]) flags_d[1:0] = ALUFlags[1:0];
            end
         end
         S_ALUWB: begin
            RegW    = cond_ex & ~dec_no_write;
            PCWrite = cond_ex & ~dec_no_write & (rd == 4'hF);
         end
         S_BRANCH: begin
            ALUSrcB   = 2'b01;
            ResultSrc = 2'b10;
            PCWrite   = cond_ex;
         end
         default: ;
      endcase

      if (reset) begin
         PCWrite = 1'b0;
         IRWrite = 1'b0;
         MemW    = 1'b0;
         RegW    = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed per-cycle vector table for multicycle_controller, plus latency and field-decode sequences.
module tb_multicycle_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] Instr;
   logic [3:0]  ALUFlags;
   logic        PCWrite, AdrSrc, MemW, IRWrite, ALUSrcA, RegW;
   logic [1:0]  ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
   logic [3:0]  Flags, State;

   multicycle_controller dut (
      .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
      .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemW(MemW), .IRWrite(IRWrite),
      .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
      .RegW(RegW), .Flags(Flags), .State(State)
   );

   always #5 clk = ~clk;

   localparam logic [31:0] I_ADDS  = 32'hE2921005;
   localparam logic [31:0] I_CMP   = 32'hE3510000;
   localparam logic [31:0] I_BEQ   = 32'h0A000002;
   localparam logic [31:0] I_BNE   = 32'h1A000002;
   localparam logic [31:0] I_LDR   = 32'hE5921000;
   localparam logic [31:0] I_LDRPC = 32'hE592F000;
   localparam logic [31:0] I_STRNE = 32'h15821000;
   localparam logic [31:0] I_STRU0 = 32'hE5021004;
   localparam logic [31:0] I_AND   = 32'hE2110001;
   localparam logic [31:0] I_UNDEF = 32'hEC000000;
   localparam logic [31:0] I_ADDR  = 32'hE0821003;
   localparam logic [3:0]  AFX     = 4'hF;  // ALU flags outside EXEC must never be captured

   typedef struct {
      logic        rst;
      logic [31:0] ins;
      logic [3:0]  af;
      logic [19:0] exp;
   } vec_t;

   vec_t vt[$];
   int   n_vec = 0;
   int   n_err = 0;

   // en = {PCWrite, AdrSrc, MemW, IRWrite}
   function automatic vec_t mk(input logic rst, input logic [31:0] ins, input logic [3:0] af,
                               input logic [3:0] st, input logic [3:0] en, input logic [1:0] rs,
                               input logic sa, input logic [1:0] sb, input logic [1:0] ac,
                               input logic rw, input logic [3:0] fl);
      vec_t v;
      v.rst = rst;
      v.ins = ins;
      v.af  = af;
      v.exp = {st, en, rs, sa, sb, ac, rw, fl};
      return v;
   endfunction

   function automatic logic [19:0] dut_out();
      return {State, PCWrite, AdrSrc, MemW, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
              ALUControl, RegW, Flags};
   endfunction

   task automatic latency(input logic [31:0] ins, input int exp_cyc);
      int n;
      reset = 1'b0; Instr = ins; ALUFlags = AFX;
      n_vec++;
      if (State !== 4'd0) begin
         n_err++;
         $display("FAIL lat_start_%h State got %0d expected 0", ins, State);
      end
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (State !== 4'd0 && n < 20);
      n_vec++;
      if (n != exp_cyc) begin
         n_err++;
         $display("FAIL lat_%h cycles got %0d expected %0d", ins, n, exp_cyc);
      end
   endtask

   task automatic fields(input logic [31:0] ins, input logic [3:0] exp_f);
      Instr = ins;
      #1;
      n_vec++;
      if ({ImmSrc, RegSrc} !== exp_f) begin
         n_err++;
         $display("FAIL fields_%h ImmSrc/RegSrc got %b expected %b", ins, {ImmSrc, RegSrc}, exp_f);
      end
   endtask

   initial begin
      //          rst ins     af      st  en       rs     sa sb     ac     rw fl
      vt.push_back(mk(1, I_ADDS,  AFX,    0, 4'b0000, 2'b10, 1, 2'b10, 2'b00, 0, 4'b0000));
      vt.push_back(mk(0, I_ADDS,  AFX,    0, 4'b1001, 2'b10, 1, 2'b10, 2'b00, 0, 4'b0000));
      vt.push_back(mk(0, I_ADDS,  AFX,    1, 4'b0000, 2'b10, 1, 2'b10, 2'b00, 0, 4'b0000));
      vt.push_back(mk(0, I_ADDS,  4'b0110, 7, 4'b0000, 2'b00, 0, 2'b01, 2'b00, 0, 4'b0000));
      vt.push_back(mk(0, I_ADDS,  AFX,    8, 4'b0000, 2'b00, 0, 2'b00, 2'b00, 1, 4'b0110));
      vt.push_back(mk(0, I_CMP,   AFX,    0, 4'b1001, 2'b10, 1, 2'b10, 2'b00, 0, 4'b0110));
      vt.push_back(mk(0, I_CMP,   AFX,    1, 4'b0000, 2'b10, 1, 2'b10, 2'b00, 0, 4'b0110));
      vt.push_back(mk(0, I_CMP,   4'b0100, 7, 4'b0000, 2'b00, 0, 2'b01, 2'b01, 0, 4'b0110));
      vt.push_back(mk(0, I_CMP,   AFX,    8, 4'b0000, 2'b00, 0, 2'b00, 2'b00, 0, 4'b0100));
      vt.push_back(mk(0, I_BEQ,   AFX,    0, 4'b1001, 2'b10, 1, 2'b10, 2'b00, 0, 4'b0100));
      vt.push_back(mk(0, I_BEQ,   AFX,    1, 4'b0000, 2'b10, 1, 2'b10, 2'b00, 0, 4'b0100));
      vt.push_back(mk(0, I_BEQ,   AFX,    9, 4'b1000, 2'b10, 0, 2'b01, 2'b00, 0, 4'b0100));
      vt.push_back(mk(0, I_BNE,   AFX,    0, 4'b1001, 2'b10, 1, 2'b10, 2'b00, 0, 4'b0100));
      vt.push_back(mk(0, I_BNE,   AFX,    1, 4'b0000, 2'b10, 1, 2'b10, 2'b00, 0, 4'b0100));
      vt.push_back(mk(0, I_BNE,   AFX,    9, 4'b0000, 2'b10, 0, 2'b01, 2'b00, 0, 4'b0100));
      vt.push_back(mk(0, I_LDR,   AFX,    0, 4'b1001, 2'b10, 1, 2'b10, 2'b00, 0, 4'b0100));
      vt.push_back(mk(0, I_LDR,   AFX,    1, 4'b0000, 2'b10, 1, 2'b10, 2'b00, 0, 4'b0100));
      vt.push_back(mk(0, I_LDR,   AFX,    2, 4'b0000, 2'b00, 0, 2'b01, 2'b00, 0, 4'b0100));
      vt.push_back(mk(0, I_LDR,   AFX,    3, 4'b0100, 2'b00, 0, 2'b00, 2'b00, 0, 4'b0100));
      vt.push_back(mk(0, I_LDR,   AFX,    4, 4'b0000, 2'b01, 0, 2'b00, 2'b00, 1, 4'b0100));
      vt.push_back(mk(0, I_LDRPC, AFX,    0, 4'b1001, 2'b10, 1, 2'b10, 2'b00, 0, 4'b0100));
      vt.push_back(mk(0, I_LDRPC, AFX,    1, 4'b0000, 2'b10, 1, 2'b10, 2'b00, 0, 4'b0100));
      vt.push_back(mk(0, I_LDRPC, AFX,    2, 4'b0000, 2'b00, 0, 2'b01, 2'b00, 0, 4'b0100));
      vt.push_back(mk(0, I_LDRPC, AFX,    3, 4'b0100, 2'b00, 0, 2'b00, 2'b00, 0, 4'b0100));
      vt.push_back(mk(0, I_LDRPC, AFX,    4, 4'b1000, 2'b01, 0, 2'b00, 2'b00, 1, 4'b0100));
      vt.push_back(mk(0, I_STRNE, AFX,    0, 4'b1001, 2'b10, 1, 2'b10, 2'b00, 0, 4'b0100));
      vt.push_back(mk(0, I_STRNE, AFX,    1, 4'b0000, 2'b10, 1, 2'b10, 2'b00, 0, 4'b0100));
      vt.push_back(mk(0, I_STRNE, AFX,    2, 4'b0000, 2'b00, 0, 2'b01, 2'b00, 0, 4'b0100));
      vt.push_back(mk(0, I_STRNE, AFX,    5, 4'b0100, 2'b00, 0, 2'b00, 2'b00, 0, 4'b0100));
      vt.push_back(mk(0, I_ADDS,  AFX,    0, 4'b1001, 2'b10, 1, 2'b10, 2'b00, 0, 4'b0100));
      vt.push_back(mk(0, I_ADDS,  AFX,    1, 4'b0000, 2'b10, 1, 2'b10, 2'b00, 0, 4'b0100));
      vt.push_back(mk(0, I_ADDS,  4'b0001, 7, 4'b0000, 2'b00, 0, 2'b01, 2'b00, 0, 4'b0100));
      vt.push_back(mk(0, I_ADDS,  AFX,    8, 4'b0000, 2'b00, 0, 2'b00, 2'b00, 1, 4'b0001));
      vt.push_back(mk(0, I_STRNE, AFX,    0, 4'b1001, 2'b10, 1, 2'b10, 2'b00, 0, 4'b0001));
      vt.push_back(mk(0, I_STRNE, AFX,    1, 4'b0000, 2'b10, 1, 2'b10, 2'b00, 0, 4'b0001));
      vt.push_back(mk(0, I_STRNE, AFX,    2, 4'b0000, 2'b00, 0, 2'b01, 2'b00, 0, 4'b0001));
      vt.push_back(mk(0, I_STRNE, AFX,    5, 4'b0110, 2'b00, 0, 2'b00, 2'b00, 0, 4'b0001));
      vt.push_back(mk(0, I_STRU0, AFX,    0, 4'b1001, 2'b10, 1, 2'b10, 2'b00, 0, 4'b0001));
      vt.push_back(mk(0, I_STRU0, AFX,    1, 4'b0000, 2'b10, 1, 2'b10, 2'b00, 0, 4'b0001));
      vt.push_back(mk(0, I_STRU0, AFX,    2, 4'b0000, 2'b00, 0, 2'b01, 2'b01, 0, 4'b0001));
      vt.push_back(mk(0, I_STRU0, AFX,    5, 4'b0110, 2'b00, 0, 2'b00, 2'b00, 0, 4'b0001));
      vt.push_back(mk(0, I_AND,   AFX,    0, 4'b1001, 2'b10, 1, 2'b10, 2'b00, 0, 4'b0001));
      vt.push_back(mk(0, I_AND,   AFX,    1, 4'b0000, 2'b10, 1, 2'b10, 2'b00, 0, 4'b0001));
      vt.push_back(mk(0, I_AND,   4'b1111, 7, 4'b0000, 2'b00, 0, 2'b01, 2'b10, 0, 4'b0001));
      vt.push_back(mk(0, I_AND,   AFX,    8, 4'b0000, 2'b00, 0, 2'b00, 2'b00, 1, 4'b1101));
      vt.push_back(mk(0, I_UNDEF, AFX,    0, 4'b1001, 2'b10, 1, 2'b10, 2'b00, 0, 4'b1101));
      vt.push_back(mk(0, I_UNDEF, AFX,    1, 4'b0000, 2'b10, 1, 2'b10, 2'b00, 0, 4'b1101));
      vt.push_back(mk(0, I_ADDR,  AFX,    0, 4'b1001, 2'b10, 1, 2'b10, 2'b00, 0, 4'b1101));
      vt.push_back(mk(0, I_ADDR,  AFX,    1, 4'b0000, 2'b10, 1, 2'b10, 2'b00, 0, 4'b1101));
      vt.push_back(mk(0, I_ADDR,  4'b0010, 6, 4'b0000, 2'b00, 0, 2'b00, 2'b00, 0, 4'b1101));
      vt.push_back(mk(0, I_ADDR,  AFX,    8, 4'b0000, 2'b00, 0, 2'b00, 2'b00, 1, 4'b1101));
      vt.push_back(mk(0, I_LDR,   AFX,    0, 4'b1001, 2'b10, 1, 2'b10, 2'b00, 0, 4'b1101));
      vt.push_back(mk(0, I_LDR,   AFX,    1, 4'b0000, 2'b10, 1, 2'b10, 2'b00, 0, 4'b1101));
      vt.push_back(mk(0, I_LDR,   AFX,    2, 4'b0000, 2'b00, 0, 2'b01, 2'b00, 0, 4'b1101));
      vt.push_back(mk(1, I_LDR,   AFX,    3, 4'b0000, 2'b10, 1, 2'b10, 2'b00, 0, 4'b1101));
      vt.push_back(mk(0, I_ADDS,  AFX,    0, 4'b1001, 2'b10, 1, 2'b10, 2'b00, 0, 4'b0000));
      vt.push_back(mk(0, I_ADDS,  AFX,    1, 4'b0000, 2'b10, 1, 2'b10, 2'b00, 0, 4'b0000));
      vt.push_back(mk(0, I_ADDS,  4'b0110, 7, 4'b0000, 2'b00, 0, 2'b01, 2'b00, 0, 4'b0000));
      vt.push_back(mk(1, I_ADDS,  AFX,    8, 4'b0000, 2'b10, 1, 2'b10, 2'b00, 0, 4'b0110));
      vt.push_back(mk(0, I_ADDS,  AFX,    0, 4'b1001, 2'b10, 1, 2'b10, 2'b00, 0, 4'b0000));

      reset = 1'b1; Instr = I_ADDS; ALUFlags = AFX;
      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < vt.size(); i++) begin
         reset = vt[i].rst; Instr = vt[i].ins; ALUFlags = vt[i].af;
         @(negedge clk);
         n_vec++;
         if (dut_out() !== vt[i].exp) begin
            n_err++;
            $display("FAIL vec%0d {State,PAMI,RS,SA,SB,AC,RW,Flags} got %h expected %h",
                     i, dut_out(), vt[i].exp);
         end
         @(posedge clk); #1;
      end

      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;

      fields(I_BEQ, 4'b1001);
      fields(I_LDR, 4'b0110);
      fields(I_ADDS, 4'b0000);

      latency(I_ADDS, 4);
      latency(I_LDR, 5);
      latency(I_STRU0, 4);
      latency(I_BNE, 3);
      latency(I_BEQ, 3);
      latency(I_UNDEF, 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
